// File: rtl/switch_debounce4.sv
// ---------------------------------------------------------------------------
// switch_debounce4
//
// Debounces four raw mechanical switch inputs. The debounced levels feed a
// downstream 4-input AND stage. Each channel is first synchronized. The
// channel output only follows a new level after that level has been seen for
// DEBOUNCE_CYCLES consecutive synchronized cycles.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronized cycles a new level must hold
//                     before the output follows (legal 1..255)
//
// Ports
//   clk     : single clock, all state updates on the rising edge
//   rst_n   : asynchronous active-low reset
//   sw_in   : raw bouncing switch levels, bit0->a, bit1->b, bit2->c, bit3->d
//   a..d    : debounced levels (registered)
//   rise    : one-cycle pulse per channel when its debounced level goes 0->1
//   fall    : one-cycle pulse per channel when its debounced level goes 1->0
//   busy    : high while any channel has a nonzero debounce count
// ---------------------------------------------------------------------------
module switch_debounce4 #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic [3:0] rise,
   output logic [3:0] fall,
   output logic       busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The count value on which a mismatching channel takes its new level.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    sync1_q, sync1_d;
   logic [3:0]    sync2_q, sync2_d;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];
   logic [3:0]    out_q, out_d;
   logic [3:0]    rise_q, rise_d;
   logic [3:0]    fall_q, fall_d;

   // Two-flop synchronizer. Only sync2_q is used by the debounce logic.
   always_comb begin
      sync1_d = sw_in;
      sync2_d = sync1_q;
   end

   // Per-channel debounce. A sample equal to the current output clears the
   // count, so any bounce back restarts the qualification window. Edge pulses
   // are computed together with the output load. They are therefore
   // registered alongside it and show up in the first cycle of the new level.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i]  = cnt_q[i];
         out_d[i]  = out_q[i];
         rise_d[i] = 1'b0;
         fall_d[i] = 1'b0;
         if (sync2_q[i] == out_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            out_d[i]  = sync2_q[i];
            cnt_d[i]  = '0;
            rise_d[i] = sync2_q[i];
            fall_d[i] = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // busy is taken directly from the count flops, so reset clears it at once.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         busy = busy | (cnt_q[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         out_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign a    = out_q[0];
   assign b    = out_q[1];
   assign c    = out_q[2];
   assign d    = out_q[3];
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_switch_debounce4.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce4
//
// Directed testbench for switch_debounce4. It drives the default
// DEBOUNCE_CYCLES=4 instance and a DEBOUNCE_CYCLES=1 instance from the same
// stimulus. Inputs change 1 time unit after a rising edge. Outputs are also
// sampled 1 time unit after a rising edge. "Edge k" is the k-th rising edge
// after an input change.
// ---------------------------------------------------------------------------
module tb_switch_debounce4;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw_in;

   logic       a, b, c, d;
   logic [3:0] rise, fall;
   logic       busy;

   logic       a1, b1, c1, d1;
   logic [3:0] rise1, fall1;
   logic       busy1;

   int checks;
   int failures;

   switch_debounce4 #(.DEBOUNCE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw_in (sw_in),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .rise  (rise),
      .fall  (fall),
      .busy  (busy)
   );

   switch_debounce4 #(.DEBOUNCE_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .sw_in (sw_in),
      .a     (a1),
      .b     (b1),
      .c     (c1),
      .d     (d1),
      .rise  (rise1),
      .fall  (fall1),
      .busy  (busy1)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against the expected value and count any
   // failure.
   task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Check all outputs of the default instance.
   task automatic checkAll(input string tag, input int k, input logic [3:0] exp_out,
                           input logic [3:0] exp_rise, input logic [3:0] exp_fall,
                           input logic exp_busy);
      checkOutput($sformatf("%s_out_e%0d", tag, k),  {d, c, b, a}, exp_out);
      checkOutput($sformatf("%s_rise_e%0d", tag, k), rise, exp_rise);
      checkOutput($sformatf("%s_fall_e%0d", tag, k), fall, exp_fall);
      checkOutput($sformatf("%s_busy_e%0d", tag, k), {3'b000, busy}, {3'b000, exp_busy});
   endtask

   task automatic applyStimulus(input logic [3:0] v);
      sw_in = v;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      sw_in    = 4'b0000;

      // Reset takes effect before any clock edge.
      #1;
      checkAll("rst_noclk", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // Reset held for 10 cycles with all switches low.
      for (int k = 1; k <= 10; k++) begin
         tick();
         checkAll("rst_hold", k, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checkAll("idle", k, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end

      // Clean 0->1 on channel a. The output follows on edge 6, and busy is
      // high after edges 3-5. The single-cycle instance follows on edge 3.
      $display("[TB] clean rise on a");
      applyStimulus(4'b0001);
      for (int k = 1; k <= 8; k++) begin
         tick();
         checkAll("a_rise", k, (k >= 6) ? 4'b0001 : 4'b0000,
                  (k == 6) ? 4'b0001 : 4'b0000, 4'b0000, (k >= 3 && k <= 5));
         checkOutput($sformatf("d1_out_e%0d", k), {d1, c1, b1, a1}, (k >= 3) ? 4'b0001 : 4'b0000);
         checkOutput($sformatf("d1_rise_e%0d", k), rise1, (k == 3) ? 4'b0001 : 4'b0000);
         checkOutput($sformatf("d1_fall_e%0d", k), fall1, 4'b0000);
         checkOutput($sformatf("d1_busy_e%0d", k), {3'b000, busy1}, 4'b0000);
      end

      // A 3-cycle pulse on b is too short. The count reaches 3 and then
      // clears without loading.
      $display("[TB] short pulse on b");
      applyStimulus(4'b0011);
      for (int k = 1; k <= 10; k++) begin
         tick();
         checkAll("b_short", k, 4'b0001, 4'b0000, 4'b0000, (k >= 3 && k <= 5));
         if (k == 3) applyStimulus(4'b0001);
      end

      // c bounces 1,0,1,0,1 and then stays high. Each bounce restarts the
      // count, and c loads on edge 10, the 6th edge after the last transition.
      $display("[TB] bouncing c");
      applyStimulus(4'b0101);
      for (int k = 1; k <= 12; k++) begin
         tick();
         checkAll("c_bounce", k, (k >= 10) ? 4'b0101 : 4'b0001,
                  (k == 10) ? 4'b0100 : 4'b0000, 4'b0000,
                  (k == 3 || k == 5 || k == 7 || k == 8 || k == 9));
         if (k <= 4) applyStimulus({1'b0, ~k[0], 1'b0, 1'b1});
      end

      // Asynchronous reset between edges clears outputs at once, with no pulse.
      $display("[TB] async reset mid-operation");
      #2;
      rst_n = 1'b0;
      applyStimulus(4'b0000);
      #1;
      checkAll("rst_async", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      for (int k = 1; k <= 2; k++) begin
         tick();
         checkAll("rst_async_hold", k, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checkAll("idle2", k, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end

      // All four channels rise together, then fall together 20 cycles later.
      $display("[TB] all channels together");
      applyStimulus(4'b1111);
      for (int k = 1; k <= 20; k++) begin
         tick();
         checkAll("all_rise", k, (k >= 6) ? 4'b1111 : 4'b0000,
                  (k == 6) ? 4'b1111 : 4'b0000, 4'b0000, (k >= 3 && k <= 5));
         checkOutput($sformatf("and_e%0d", k), {3'b000, a & b & c & d}, {3'b000, (k >= 6)});
      end
      applyStimulus(4'b0000);
      for (int k = 1; k <= 8; k++) begin
         tick();
         checkAll("all_fall", k, (k >= 6) ? 4'b0000 : 4'b1111,
                  4'b0000, (k == 6) ? 4'b1111 : 4'b0000, (k >= 3 && k <= 5));
         checkOutput($sformatf("and_fall_e%0d", k), {3'b000, a & b & c & d}, {3'b000, (k < 6)});
      end

      // Bring d high, then begin a release and reset with cnt[3]=2.
      $display("[TB] reset with d mid-count");
      applyStimulus(4'b1000);
      for (int k = 1; k <= 8; k++) begin
         tick();
         checkAll("d_rise", k, (k >= 6) ? 4'b1000 : 4'b0000,
                  (k == 6) ? 4'b1000 : 4'b0000, 4'b0000, (k >= 3 && k <= 5));
      end
      applyStimulus(4'b0000);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checkAll("d_count", k, 4'b1000, 4'b0000, 4'b0000, (k >= 3));
      end
      #2;
      rst_n = 1'b0;
      applyStimulus(4'b1111);
      #1;
      checkAll("rst_cnt", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      checkAll("rst_cnt_hold", 1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      rst_n = 1'b1;

      // After release, the held-high switches count as a new 0->1 change.
      for (int k = 1; k <= 8; k++) begin
         tick();
         checkAll("post_rst", k, (k >= 6) ? 4'b1111 : 4'b0000,
                  (k == 6) ? 4'b1111 : 4'b0000, 4'b0000, (k >= 3 && k <= 5));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/switch_debounce4.md
SWITCH_DEBOUNCE4 -- requirements
Module: switch_debounce4

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive synchronized cycles an input must hold a new level before the output follows (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sw_in, input, 4 bits: raw, asynchronous, bouncing switch levels; bit 0 drives a, bit 1 drives b, bit 2 drives c, bit 3 drives d.
REQ-005 The block SHALL have ports a, b, c, d, each output, 1 bit: debounced levels that feed the four inputs of the downstream 4-input AND stage.
REQ-006 The block SHALL have port rise, output, 4 bits: one-cycle pulse per channel when that debounced output goes 0->1.
REQ-007 The block SHALL have port fall, output, 4 bits: one-cycle pulse per channel when that debounced output goes 1->0.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any channel has a nonzero debounce count.

Function
REQ-009 Each sw_in bit SHALL pass through a 2-flop synchronizer; s[i] denotes the second-flop output, and no other logic SHALL sample sw_in directly.
REQ-010 Each channel SHALL have an independent counter cnt[i], width $clog2(DEBOUNCE_CYCLES+1), and a registered output out[i] (out[0]=a ... out[3]=d).
REQ-011 On any edge where s[i] == out[i]: cnt[i] SHALL be cleared to 0 and out[i] held.
REQ-012 On an edge where s[i] != out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] SHALL increment by 1 and out[i] hold.
REQ-013 On an edge where s[i] != out[i] and cnt[i] == DEBOUNCE_CYCLES-1: out[i] SHALL load s[i] and cnt[i] SHALL clear to 0.
REQ-014 The counter SHALL never exceed DEBOUNCE_CYCLES-1, so no wrap-around or saturation logic is required.
REQ-015 Latency: for a clean level change first sampled at edge 1, out[i] SHALL change on edge DEBOUNCE_CYCLES+2 (edge 6 for the default).
REQ-016 A pulse on s[i] shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on out[i] and no rise/fall pulse.
REQ-017 Any return of s[i] to out[i] mid-count (bounce) SHALL restart the count from 0.
REQ-018 rise[i] and fall[i] SHALL be registered and asserted for exactly the one cycle in which out[i] holds its new value after the REQ-013 edge.
REQ-019 rise[i] and fall[i] SHALL never be asserted together.
REQ-020 Channels SHALL be fully independent; simultaneous qualifying changes on several channels SHALL update those outputs and pulses on the same edge.
REQ-021 busy SHALL be combinational OR of (cnt[i] != 0) over all channels.
REQ-022 With DEBOUNCE_CYCLES=1, out[i] SHALL follow s[i] with one register stage (edge 3 latency).

Reset
REQ-023 While rst_n is low, the synchronizer flops, cnt, a, b, c, d, rise, fall SHALL be 0 and busy SHALL be 0, independent of clk.
REQ-024 Assertion of rst_n mid-count SHALL immediately clear outputs and counts; no pulse SHALL be emitted for the cleared state.
REQ-025 After rst_n rises, a channel whose sw_in is held at 1 SHALL be treated as a new 0->1 change and rise after DEBOUNCE_CYCLES+2 edges with a rise pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset with sw_in=4'b0000, 10 cycles -> a..d=0, rise=fall=4'b0000, busy=0 throughout.
REQ-027 sw_in[0] 0->1 held -> a=1 from edge 6, rise=4'b0001 for exactly one cycle, busy high edges 3-5 only.
REQ-028 sw_in[1] high for 3 cycles then low -> b stays 0, rise/fall stay 0, busy returns to 0.
REQ-029 sw_in[2] toggles 1,0,1,0,1 on consecutive cycles then held 1 -> c rises on the 6th edge after the last transition, single rise[2] pulse.
REQ-030 sw_in 4'b0000->4'b1111 in one cycle, then ->4'b0000 after 20 cycles -> rise=4'b1111 one cycle, later fall=4'b1111 one cycle, downstream AND output tracks a&b&c&d.
REQ-031 rst_n driven low between clock edges with cnt[3]=2 and d=1 -> d, cnt, busy clear at once; release with sw_in=4'b1111 -> a..d rise on edge 6.
